// File: rtl/unidade_controle_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : unidade_controle_multiciclo
// Description : Multicycle control FSM for a small accumulator/ALU datapath.
//               Sequences FETCH -> DECODE -> EXECUTE -> (MEMORY) ->
//               (WRITEBACK), drives ALU opcode, operand selects and the
//               IR/PC/memory/register-file strobes, and resolves conditional
//               branches from the ALU compare flags.
//               Optional feature macro: INSTR_COUNTER_EN (retired-instruction
//               counter on instr_count; tied to zero when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module unidade_controle_multiciclo #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                maior,
  input  logic                igual,
  input  logic                menor,
  input  logic                mem_ready,
  output logic [ALUOP_W-1:0]  aluOp,
  output logic [1:0]          alu_src_b,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                illegal,
  output logic                halted,
  output logic [31:0]         instr_count
);

  // Opcode map
  localparam logic [OPCODE_W-1:0] c_OP_MOV  = OPCODE_W'(6'h0A);
  localparam logic [OPCODE_W-1:0] c_OP_ADDI = OPCODE_W'(6'h10);
  localparam logic [OPCODE_W-1:0] c_OP_SUBI = OPCODE_W'(6'h11);
  localparam logic [OPCODE_W-1:0] c_OP_LI   = OPCODE_W'(6'h12);
  localparam logic [OPCODE_W-1:0] c_OP_LW   = OPCODE_W'(6'h13);
  localparam logic [OPCODE_W-1:0] c_OP_SW   = OPCODE_W'(6'h14);
  localparam logic [OPCODE_W-1:0] c_OP_BEQ  = OPCODE_W'(6'h15);
  localparam logic [OPCODE_W-1:0] c_OP_BNE  = OPCODE_W'(6'h16);
  localparam logic [OPCODE_W-1:0] c_OP_BGT  = OPCODE_W'(6'h17);
  localparam logic [OPCODE_W-1:0] c_OP_BLT  = OPCODE_W'(6'h18);
  localparam logic [OPCODE_W-1:0] c_OP_JMP  = OPCODE_W'(6'h19);
  localparam logic [OPCODE_W-1:0] c_OP_HALT = OPCODE_W'(6'h3F);

  // ALU codes used outside the R-type passthrough
  localparam logic [ALUOP_W-1:0] c_ALU_ADD = ALUOP_W'(4'b0000);
  localparam logic [ALUOP_W-1:0] c_ALU_SUB = ALUOP_W'(4'b0001);
  localparam logic [ALUOP_W-1:0] c_ALU_LI  = ALUOP_W'(4'b1011);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ALUOP_W-1:0] w_aluop;
  logic [1:0]         w_src_b;
  logic               w_ir_write;
  logic               w_pc_write;
  logic [1:0]         w_pc_src;
  logic               w_mem_read;
  logic               w_mem_write;
  logic               w_mem_to_reg;
  logic               w_reg_write;
  logic               w_illegal;
  logic               w_halted;
  logic               w_retire;

  // Opcode classes
  logic w_is_rtype, w_is_imm, w_is_lw, w_is_sw, w_is_branch, w_is_jmp, w_is_halt;
  logic w_is_legal, w_taken;

  assign w_is_rtype  = (opcode <= c_OP_MOV);
  assign w_is_imm    = (opcode == c_OP_ADDI) || (opcode == c_OP_SUBI) || (opcode == c_OP_LI);
  assign w_is_lw     = (opcode == c_OP_LW);
  assign w_is_sw     = (opcode == c_OP_SW);
  assign w_is_branch = (opcode >= c_OP_BEQ) && (opcode <= c_OP_BLT);
  assign w_is_jmp    = (opcode == c_OP_JMP);
  assign w_is_halt   = (opcode == c_OP_HALT);
  assign w_is_legal  = w_is_rtype | w_is_imm | w_is_lw | w_is_sw | w_is_branch | w_is_jmp;

  // Branch condition from the flags presented during EXECUTE
  always_comb begin
    w_taken = 1'b0;
    case (opcode)
      c_OP_BEQ: w_taken = igual;
      c_OP_BNE: w_taken = ~igual;
      c_OP_BGT: w_taken = maior;
      c_OP_BLT: w_taken = menor;
      default:  w_taken = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and control decode
  always_comb begin
    w_next       = r_state;
    w_aluop      = '0;
    w_src_b      = 2'd0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = 2'd0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_illegal    = 1'b0;
    w_halted     = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        if (mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_pc_src   = 2'd0;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_is_halt) begin
          w_next = S_HALT;
        end else if (!w_is_legal) begin
          // Undefined opcode behaves as a NOP that is not retired
          w_illegal = 1'b1;
          w_next    = S_FETCH;
        end else begin
          w_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (w_is_rtype) begin
          w_aluop = ALUOP_W'(opcode[3:0]);
          w_src_b = 2'd0;
          w_next  = S_WRITEBACK;
        end else if (w_is_imm) begin
          w_aluop = (opcode == c_OP_ADDI) ? c_ALU_ADD :
                    (opcode == c_OP_SUBI) ? c_ALU_SUB : c_ALU_LI;
          w_src_b = 2'd1;
          w_next  = S_WRITEBACK;
        end else if (w_is_lw || w_is_sw) begin
          w_aluop = c_ALU_ADD;
          w_src_b = 2'd1;
          w_next  = S_MEMORY;
        end else if (w_is_branch) begin
          w_aluop    = c_ALU_SUB;
          w_src_b    = 2'd0;
          w_pc_write = w_taken;
          w_pc_src   = w_taken ? 2'd1 : 2'd0;
          w_retire   = 1'b1;
          w_next     = S_FETCH;
        end else if (w_is_jmp) begin
          w_pc_write = 1'b1;
          w_pc_src   = 2'd2;
          w_retire   = 1'b1;
          w_next     = S_FETCH;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_MEMORY: begin
        // Address operands stay as computed in EXECUTE
        w_aluop     = c_ALU_ADD;
        w_src_b     = 2'd1;
        w_mem_read  = w_is_lw;
        w_mem_write = w_is_sw;
        if (mem_ready) begin
          if (w_is_lw) begin
            w_next = S_WRITEBACK;
          end else begin
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end
        end
      end
      S_WRITEBACK: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = w_is_lw;
        w_retire     = 1'b1;
        w_next       = S_FETCH;
      end
      S_HALT: begin
        w_halted = 1'b1;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Every control output is held at zero while reset is asserted
  assign aluOp      = reset ? w_aluop      : '0;
  assign alu_src_b  = reset ? w_src_b      : 2'd0;
  assign ir_write   = reset & w_ir_write;
  assign pc_write   = reset & w_pc_write;
  assign pc_src     = reset ? w_pc_src     : 2'd0;
  assign mem_read   = reset & w_mem_read;
  assign mem_write  = reset & w_mem_write;
  assign mem_to_reg = reset & w_mem_to_reg;
  assign reg_write  = reset & w_reg_write;
  assign illegal    = reset & w_illegal;
  assign halted     = reset & w_halted;

`ifdef INSTR_COUNTER_EN
  logic [31:0] r_instr_count;

  // Retired-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_instr_count <= 32'd0;
    end else if (w_retire) begin
      r_instr_count <= r_instr_count + 32'd1;
    end
  end

  assign instr_count = r_instr_count;
`else
  logic w_unused_retire;
  assign w_unused_retire = w_retire;
  assign instr_count     = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_unidade_controle_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : tb_unidade_controle_multiciclo
// Description : Self-checking bench for unidade_controle_multiciclo. An
//               instruction-level model expands each instruction into its
//               expected per-cycle control vectors; a monitor compares them
//               against the DUT on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unidade_controle_multiciclo;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        maior, igual, menor, mem_ready;
  logic [3:0]  aluOp;
  logic [1:0]  alu_src_b, pc_src;
  logic        ir_write, pc_write, mem_read, mem_write, mem_to_reg, reg_write;
  logic        illegal, halted;
  logic [31:0] instr_count;

  unidade_controle_multiciclo #(.OPCODE_W(6), .ALUOP_W(4)) dut (
    .clock(clock), .reset(reset), .opcode(opcode),
    .maior(maior), .igual(igual), .menor(menor), .mem_ready(mem_ready),
    .aluOp(aluOp), .alu_src_b(alu_src_b), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal(illegal), .halted(halted), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]  aluop;
    logic [1:0]  srcb;
    logic        irw;
    logic        pcw;
    logic [1:0]  pcs;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        rw;
    logic        ill;
    logic        hlt;
    logic [31:0] cnt;
  } vec_t;

  vec_t        exp_q[$];
  string       tag_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] cnt_model = 32'd0;

  // Baseline vector: no strobes, current retired count
  function automatic vec_t idle();
    vec_t v;
    v = '0;
`ifdef INSTR_COUNTER_EN
    v.cnt = cnt_model;
`endif
    return v;
  endfunction

  // Monitor: compare one expected vector per cycle, away from the rising edge
  always @(negedge clock) begin
    vec_t  e;
    vec_t  a;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {aluOp, alu_src_b, ir_write, pc_write, pc_src, mem_read, mem_write,
           mem_to_reg, reg_write, illegal, halted, instr_count};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s @%0t: got %h required %h", t, $time, a, e);
      end
    end
  end

  // One clock of stimulus with its expected outputs; entered at posedge+1
  task automatic cyc(input logic [5:0] op, input logic mrdy, input logic [2:0] fl,
                     input vec_t e, input string tag);
    opcode    = op;
    mem_ready = mrdy;
    {maior, igual, menor} = fl;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b0;
    cnt_model = 32'd0;
    for (int i = 0; i < n; i++)
      cyc(6'($urandom), 1'b1, 3'($urandom), idle(), "reset");
    reset = 1'b1;
  endtask

  // Expand one instruction into its cycle-by-cycle expected behaviour.
  // abort_at >= 0 asserts reset after that many MEMORY wait cycles.
  task automatic run_instr(input logic [5:0] op, input int fwait, input int mwait,
                           input logic [2:0] fl, input int abort_at);
    vec_t e;
    bit   rtype, imm, lw, sw, br, jmp, hlt, legal, taken;
    rtype = (op <= 6'h0A);
    imm   = (op >= 6'h10 && op <= 6'h12);
    lw    = (op == 6'h13);
    sw    = (op == 6'h14);
    br    = (op >= 6'h15 && op <= 6'h18);
    jmp   = (op == 6'h19);
    hlt   = (op == 6'h3F);
    legal = rtype | imm | lw | sw | br | jmp;

    // Fetch, with optional memory wait
    for (int i = 0; i < fwait; i++) begin
      e = idle(); e.mr = 1'b1;
      cyc(6'($urandom), 1'b0, 3'($urandom), e, "fetch_wait");
    end
    e = idle(); e.mr = 1'b1; e.irw = 1'b1; e.pcw = 1'b1; e.pcs = 2'd0;
    cyc(6'($urandom), 1'b1, 3'($urandom), e, "fetch_done");

    // Decode
    e = idle();
    if (!hlt && !legal) e.ill = 1'b1;
    cyc(op, 1'($urandom), 3'($urandom), e, "decode");
    if (!hlt && !legal) return;
    if (hlt) begin
      for (int i = 0; i < 20; i++) begin
        e = idle(); e.hlt = 1'b1;
        cyc(6'($urandom), 1'($urandom), 3'($urandom), e, "halt");
      end
      return;
    end

    // Execute
    e = idle();
    if (rtype)    begin e.aluop = op[3:0]; e.srcb = 2'd0; end
    if (op == 6'h10) begin e.aluop = 4'b0000; e.srcb = 2'd1; end
    if (op == 6'h11) begin e.aluop = 4'b0001; e.srcb = 2'd1; end
    if (op == 6'h12) begin e.aluop = 4'b1011; e.srcb = 2'd1; end
    if (lw || sw) begin e.aluop = 4'b0000; e.srcb = 2'd1; end
    if (br) begin
      // fl = {maior, igual, menor}
      case (op)
        6'h15:   taken = fl[1];
        6'h16:   taken = !fl[1];
        6'h17:   taken = fl[2];
        default: taken = fl[0];
      endcase
      e.aluop = 4'b0001; e.srcb = 2'd0;
      if (taken) begin e.pcw = 1'b1; e.pcs = 2'd1; end
    end
    if (jmp) begin e.pcw = 1'b1; e.pcs = 2'd2; end
    cyc(op, 1'($urandom), fl, e, "execute");
    if (br || jmp) begin cnt_model = cnt_model + 32'd1; return; end

    // Memory access
    if (lw || sw) begin
      for (int i = 0; i < mwait; i++) begin
        if (i == abort_at) begin
          do_reset(2);
          return;
        end
        e = idle(); e.aluop = 4'b0000; e.srcb = 2'd1; e.mr = lw; e.mw = sw;
        cyc(op, 1'b0, 3'($urandom), e, "mem_wait");
      end
      e = idle(); e.aluop = 4'b0000; e.srcb = 2'd1; e.mr = lw; e.mw = sw;
      cyc(op, 1'b1, 3'($urandom), e, "mem_done");
      if (sw) begin cnt_model = cnt_model + 32'd1; return; end
    end

    // Writeback
    e = idle(); e.rw = 1'b1; e.m2r = lw;
    cyc(op, 1'($urandom), 3'($urandom), e, "writeback");
    cnt_model = cnt_model + 32'd1;
  endtask

  initial begin
    logic [5:0] op;
    int         k;
    reset = 1'b0; opcode = '0; mem_ready = 1'b0;
    maior = 1'b0; igual = 1'b0; menor = 1'b0;
    @(posedge clock);
    #1;
    do_reset(3);

    // Directed cases
    run_instr(6'h00, 0, 0, 3'b000, -1);  // ADD
    run_instr(6'h13, 0, 3, 3'b000, -1);  // LW with 3 wait cycles
    run_instr(6'h15, 0, 0, 3'b010, -1);  // BEQ taken
    run_instr(6'h15, 0, 0, 3'b100, -1);  // BEQ not taken
    run_instr(6'h18, 0, 0, 3'b001, -1);  // BLT taken
    run_instr(6'h2A, 0, 0, 3'b000, -1);  // illegal
    run_instr(6'h14, 1, 0, 3'b000, -1);  // SW
    run_instr(6'h14, 0, 4, 3'b000, 2);   // reset during SW memory wait
    run_instr(6'h19, 0, 0, 3'b000, -1);  // JMP after reset

    // Randomized instruction stream
    for (int n = 0; n < 250; n++) begin
      k = $urandom_range(0, 24);
      if (k <= 10)      op = 6'(k);
      else if (k <= 20) op = 6'(16 + k - 11);
      else if (k == 21) op = 6'($urandom_range(11, 15));
      else              op = 6'($urandom_range(26, 62));
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), 3'($urandom), -1);
    end

`ifdef INSTR_COUNTER_EN
    // Counter wrap: preload all-ones, next retire must read back zero
    force dut.r_instr_count = 32'hFFFF_FFFF;
    #2;
    release dut.r_instr_count;
    cnt_model = 32'hFFFF_FFFF;
    run_instr(6'h01, 0, 0, 3'b000, -1);
    run_instr(6'h19, 0, 0, 3'b000, -1);
`endif

    // Halt is absorbing
    run_instr(6'h3F, 0, 0, 3'b000, -1);

    repeat (3) @(negedge clock);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/unidade_controle_multiciclo.md
Name: unidade_controle_multiciclo

Overview:
- Multicycle control FSM that drives the ALU: issues aluOp, operand selects and register/memory/PC strobes.
- Consumes the ALU compare flags (maior/igual/menor) to resolve conditional branches.
- Sits between instruction register, register file, memory interface and PC; one instruction in flight at a time.

Parameters:
- OPCODE_W, 6, instruction opcode width
- ALUOP_W, 4, ALU operation code width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- opcode  in  6  opcode field from instruction register (valid from DECODE onward)
- maior  in  1  ALU flag A>B (unsigned)
- igual  in  1  ALU flag A==B
- menor  in  1  ALU flag A<B (unsigned)
- mem_ready  in  1  memory handshake: access completes this cycle
- aluOp  out  4  ALU operation code
- alu_src_b  out  2  B operand select: 0=reg rt, 1=immediate, 2=constant 1
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- pc_src  out  2  PC source: 0=PC+1, 1=PC+imm (branch), 2=jump target
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_to_reg  out  1  writeback data select: 1=memory, 0=ALU result
- reg_write  out  1  register file write enable
- illegal  out  1  one-cycle pulse, undefined opcode decoded
- halted  out  1  core stopped
- instr_count  out  32  retired-instruction count (see optional feature)

Behaviour:
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT. Outputs are combinational decodes of state, opcode, flags and mem_ready. All strobes are 0 outside the states listed below.
- Reset (reset=0, async, any state, including mid-access): state=FETCH. While reset=0, every output is forced to 0 (aluOp=0000, selects=0). The first fetch starts on the first rising edge after release.
- FETCH: mem_read=1. Stay in FETCH while mem_ready=0. When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, and go to DECODE.
- DECODE: no strobes; one cycle. Go to HALT for 0x3F. For an undefined opcode: illegal=1, go to FETCH (treated as a NOP, not retired). Otherwise go to EXECUTE.
- EXECUTE, by opcode:
  - 0x00-0x0A (R-type ADD, SUB, MUL, DIV, AND, OR, XOR, NOT, SHL, SHR, MOV): aluOp=opcode[3:0], alu_src_b=0, go to WRITEBACK.
  - 0x10 ADDI: aluOp=0000, src_b=1. 0x11 SUBI: aluOp=0001, src_b=1. 0x12 LI: aluOp=1011, src_b=1. All three go to WRITEBACK.
  - 0x13 LW / 0x14 SW: aluOp=0000, src_b=1 (address calculation), go to MEMORY.
  - 0x15 BEQ / 0x16 BNE / 0x17 BGT / 0x18 BLT: aluOp=0001, src_b=0. pc_write=1 with pc_src=1 iff the condition holds (igual, !igual, maior, menor respectively), sampled in the same cycle. Retire, go to FETCH.
  - 0x19 JMP: pc_write=1, pc_src=2. Retire, go to FETCH.
- MEMORY: LW holds mem_read=1 and SW holds mem_write=1 until mem_ready=1.
  - LW then goes to WRITEBACK.
  - SW retires and goes to FETCH.
  - aluOp and src_b are held from EXECUTE.
- WRITEBACK: reg_write=1. mem_to_reg=1 for LW, 0 otherwise. Retire, go to FETCH.
- HALT: halted=1; absorbing until reset.
- Latency with mem_ready=1: R-type/imm 4 cycles, LW 5, SW 4, branch/JMP 3, illegal 2.
- A branch and a flag change never interact: flags are used only in the EXECUTE cycle.

Optional Feature:
- Macro INSTR_COUNTER_EN.
- Defined: 32-bit instr_count resets to 0 and increments by 1 on every retire event (the end of WRITEBACK, SW MEMORY, branch/JMP EXECUTE). It wraps 0xFFFFFFFF to 0. Illegal opcodes and HALT do not count.
- Undefined: instr_count is tied to 0 and no counter register exists.

Test Plan:
- ADD (0x00), mem_ready=1 -> states F,D,E,W over 4 cycles; aluOp=0000 in E; reg_write=1 only in W; instr_count=1.
- LW (0x13), mem_ready held low 3 cycles in MEMORY -> mem_read stays 1 for 4 cycles; then W with mem_to_reg=1, reg_write=1.
- BEQ with igual=1 -> pc_write=1, pc_src=1 in E. Repeat with igual=0 -> pc_write=0. BLT with menor=1 -> pc_write=1.
- Opcode 0x2A -> illegal=1 for exactly one cycle in DECODE; next state FETCH; no reg_write/mem_write; count unchanged.
- 0x3F -> halted=1 persists for 20 cycles with no strobes. Assert reset=0 mid-SW MEMORY -> all outputs 0 immediately; after release, FETCH with mem_read=1.
- INSTR_COUNTER_EN, preload via 2^32-1 retires (or force) -> next retire gives instr_count=0.
